// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant among NUM_MST masters. The grant is
// held for the whole of a defined-length burst and for the whole of a
// locked sequence. A retry or error response cuts the burst short. When
// nobody requests, the bus is parked on DEFAULT_MST.
module ahb_arbiter #(
  parameter int NUM_MST     = 4,
  parameter int DEFAULT_MST = 0
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [NUM_MST-1:0] hbusreq_i,
  input  logic [NUM_MST-1:0] hlock_i,
  input  logic [1:0]         htrans_i,
  input  logic [2:0]         hburst_i,
  input  logic               hready_i,
  input  logic [1:0]         hresp_i,
  output logic [NUM_MST-1:0] hgrant_o,
  output logic [2:0]         hmaster_o,
  output logic               hmastlock_o
);

  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;
  localparam logic [1:0] RESP_ERROR   = 2'd1;
  localparam logic [1:0] RESP_RETRY   = 2'd2;

  localparam logic [NUM_MST-1:0] GRANT_ONE   = {{(NUM_MST-1){1'b0}}, 1'b1};
  localparam logic [NUM_MST-1:0] RESET_GRANT = GRANT_ONE << DEFAULT_MST;
  localparam logic [2:0]         DEFAULT_IDX = 3'(DEFAULT_MST);

  logic [NUM_MST-1:0] hgrant_q, hgrant_d;
  logic [2:0]         hmaster_q, hmaster_d;
  logic               hmastlock_q, hmastlock_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               lock_q, lock_d;
  logic [2:0]         ptr_q, ptr_d;

  logic [2:0]         owner_idx;
  logic               owner_lock;
  logic               rearb;
  logic               win_found;
  logic [2:0]         win_idx;

  // Beats still to come after the NONSEQ beat, by burst type.
  function automatic logic [3:0] burst_remaining(input logic [2:0] burst);
    logic [3:0] rem;
    case (burst)
      3'd2, 3'd3: rem = 4'd3;
      3'd4, 3'd5: rem = 4'd7;
      3'd6, 3'd7: rem = 4'd15;
      default:    rem = 4'd0;
    endcase
    return rem;
  endfunction

  // Decode the current grant holder and pick up its lock request.
  always_comb begin
    owner_idx  = DEFAULT_IDX;
    owner_lock = 1'b0;
    for (int j = 0; j < NUM_MST; j++) begin
      if (hgrant_q[j]) begin
        owner_idx  = 3'(j);
        owner_lock = hlock_i[j];
      end
    end
  end

  // Beat counter and lock tracking decide whether this edge may re-arbitrate.
  always_comb begin
    cnt_d = cnt_q;
    if (hready_i) begin
      if (htrans_i == TRANS_NONSEQ) begin
        cnt_d = burst_remaining(hburst_i);
      end else if (htrans_i == TRANS_SEQ && cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (hresp_i == RESP_RETRY || hresp_i == RESP_ERROR) begin
      cnt_d = 4'd0;
    end

    lock_d = lock_q;
    if (hready_i && (htrans_i == TRANS_NONSEQ || htrans_i == TRANS_SEQ)) begin
      lock_d = owner_lock;
    end

    rearb = hready_i && (cnt_d == 4'd0) && !lock_d;
  end

  // Round-robin search starting just after the last winning master.
  always_comb begin
    win_found = 1'b0;
    win_idx   = DEFAULT_IDX;
    for (int off = 1; off <= NUM_MST; off++) begin
      for (int j = 0; j < NUM_MST; j++) begin
        if (!win_found && hbusreq_i[j] && (j == (int'(ptr_q) + off) % NUM_MST)) begin
          win_found = 1'b1;
          win_idx   = 3'(j);
        end
      end
    end

    hgrant_d = hgrant_q;
    ptr_d    = ptr_q;
    if (rearb) begin
      if (win_found) begin
        hgrant_d = GRANT_ONE << win_idx;
        ptr_d    = win_idx;
      end else begin
        hgrant_d = RESET_GRANT;
      end
    end
  end

  // The address-phase owner and its lock status follow the grant on ready edges.
  always_comb begin
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (hready_i) begin
      hmaster_d   = owner_idx;
      hmastlock_d = lock_d;
    end
  end

  // State registers; reset parks the bus on the default master.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hgrant_q    <= RESET_GRANT;
      hmaster_q   <= DEFAULT_IDX;
      hmastlock_q <= 1'b0;
      cnt_q       <= 4'd0;
      lock_q      <= 1'b0;
      ptr_q       <= DEFAULT_IDX;
    end else begin
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      cnt_q       <= cnt_d;
      lock_q      <= lock_d;
      ptr_q       <= ptr_d;
    end
  end

  assign hgrant_o    = hgrant_q;
  assign hmaster_o   = hmaster_q;
  assign hmastlock_o = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter. Directed scenarios and random traffic are both
// checked every cycle against a behavioural model of the arbitration rules.
module tb_ahb_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] INCR8  = 3'd5;
  localparam logic [2:0] INCR16 = 3'd7;
  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] RETRY  = 2'd2;

  logic         hclk      = 1'b0;
  logic         hresetn   = 1'b1;
  logic [N-1:0] hbusreq_i = '0;
  logic [N-1:0] hlock_i   = '0;
  logic [1:0]   htrans_i  = IDLE;
  logic [2:0]   hburst_i  = SINGLE;
  logic         hready_i  = 1'b1;
  logic [1:0]   hresp_i   = OKAY;
  logic [N-1:0] hgrant_o;
  logic [2:0]   hmaster_o;
  logic         hmastlock_o;

  always #5 hclk = ~hclk;

  ahb_arbiter #(.NUM_MST(N), .DEFAULT_MST(DEF)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hbusreq_i   (hbusreq_i),
    .hlock_i     (hlock_i),
    .htrans_i    (htrans_i),
    .hburst_i    (hburst_i),
    .hready_i    (hready_i),
    .hresp_i     (hresp_i),
    .hgrant_o    (hgrant_o),
    .hmaster_o   (hmaster_o),
    .hmastlock_o (hmastlock_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: beats left in the burst, lock held, granted
  // master, last winner, address-phase owner and its lock flag.
  int mCnt, mLock, mOwn, mPtr, mMaster, mMlock;
  int beatsOf [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  logic [3:0] rrGrant  [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  int         rrMaster [5] = '{0, 1, 2, 3, 0};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    mCnt = 0; mLock = 0; mOwn = DEF; mPtr = DEF; mMaster = DEF; mMlock = 0;
  endfunction

  // One rising edge of the arbitration rules, using the inputs now applied.
  function automatic void modelEdge();
    int  nCnt  = mCnt;
    int  nLock = mLock;
    bit  xfer  = hready_i && (htrans_i == NONSEQ || htrans_i == SEQ);
    bit  found = 0;
    if (hready_i) begin
      if (htrans_i == NONSEQ) nCnt = beatsOf[hburst_i] - 1;
      else if (htrans_i == SEQ && mCnt > 0) nCnt = mCnt - 1;
    end else if (hresp_i == 2'd1 || hresp_i == 2'd2) begin
      nCnt = 0;
    end
    if (xfer) nLock = int'(hlock_i[mOwn]);
    if (hready_i) begin
      mMaster = mOwn;
      mMlock  = nLock;
    end
    if (hready_i && nCnt == 0 && nLock == 0) begin
      if (hbusreq_i == '0) begin
        mOwn = DEF;
      end else begin
        for (int off = 1; off <= N && !found; off++) begin
          int c = (mPtr + off) % N;
          if (hbusreq_i[c]) begin
            mOwn  = c;
            mPtr  = c;
            found = 1;
          end
        end
      end
    end
    mCnt  = nCnt;
    mLock = nLock;
  endfunction

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] lck,
                               input logic [1:0] trans, input logic [2:0] burst,
                               input logic ready, input logic [1:0] resp);
    hbusreq_i = req;
    hlock_i   = lck;
    htrans_i  = trans;
    hburst_i  = burst;
    hready_i  = ready;
    hresp_i   = resp;
    @(posedge hclk);
    modelEdge();
    #1;
    checkOutput("grant", 32'(hgrant_o), 32'(1) << mOwn);
    checkOutput("master", 32'(hmaster_o), 32'(mMaster));
    checkOutput("mastlock", 32'(hmastlock_o), 32'(mMlock));
    checkOutput("onehot", 32'($onehot(hgrant_o)), 32'd1);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic doReset();
    #3;
    hresetn = 1'b0;
    #1;
    checkOutput("rst_grant", 32'(hgrant_o), 32'h1);
    checkOutput("rst_master", 32'(hmaster_o), 32'h0);
    checkOutput("rst_mastlock", 32'(hmastlock_o), 32'h0);
    modelReset();
    #2;
    hresetn = 1'b1;
  endtask

  initial begin
    modelReset();
    @(posedge hclk);
    #1;

    // Round robin with everyone requesting single transfers.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY);
      checkOutput("rr_grant", 32'(hgrant_o), 32'(rrGrant[i]));
      checkOutput("rr_master", 32'(hmaster_o), 32'(rrMaster[i]));
    end

    // M1 INCR4 with two wait states while M2 waits.
    doReset();
    applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    checkOutput("burst_start", 32'(hgrant_o), 32'h2);
    applyStimulus(4'b0110, 4'b0000, NONSEQ, INCR4, 1'b1, OKAY);
    checkOutput("burst_b1", 32'(hgrant_o), 32'h2);
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
    checkOutput("burst_b2", 32'(hgrant_o), 32'h2);
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b0, OKAY);
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b0, OKAY);
    checkOutput("burst_wait", 32'(hgrant_o), 32'h2);
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
    checkOutput("burst_b3", 32'(hgrant_o), 32'h2);
    applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
    checkOutput("burst_release", 32'(hgrant_o), 32'h4);

    // M3 locked sequence while M0 requests.
    doReset();
    applyStimulus(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1001, 4'b1000, NONSEQ, SINGLE, 1'b1, OKAY);
      checkOutput("lock_grant", 32'(hgrant_o), 32'h8);
      checkOutput("lock_mastlock", 32'(hmastlock_o), 32'h1);
    end
    applyStimulus(4'b1001, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    checkOutput("lock_hold_grant", 32'(hgrant_o), 32'h8);
    checkOutput("lock_hold_mastlock", 32'(hmastlock_o), 32'h1);
    applyStimulus(4'b1001, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY);
    checkOutput("lock_release", 32'(hgrant_o), 32'h1);

    // M2 INCR8 retried on beat 3 while M0 requests.
    doReset();
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    applyStimulus(4'b0101, 4'b0000, NONSEQ, INCR8, 1'b1, OKAY);
    applyStimulus(4'b0101, 4'b0000, SEQ, INCR8, 1'b1, OKAY);
    applyStimulus(4'b0101, 4'b0000, SEQ, INCR8, 1'b1, OKAY);
    applyStimulus(4'b0101, 4'b0000, SEQ, INCR8, 1'b0, RETRY);
    checkOutput("retry_first", 32'(hgrant_o), 32'h4);
    applyStimulus(4'b0101, 4'b0000, IDLE, INCR8, 1'b1, RETRY);
    checkOutput("retry_release", 32'(hgrant_o), 32'h1);

    // Parking on the default master keeps the round-robin pointer.
    doReset();
    applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    applyStimulus(4'b0100, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY);
    checkOutput("park_sole", 32'(hgrant_o), 32'h4);
    applyStimulus(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    checkOutput("park_grant", 32'(hgrant_o), 32'h1);
    applyStimulus(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    checkOutput("park_master", 32'(hmaster_o), 32'h0);
    applyStimulus(4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    checkOutput("park_next", 32'(hgrant_o), 32'h8);

    // Reset in the middle of an M1 INCR16 burst.
    doReset();
    applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    applyStimulus(4'b0011, 4'b0000, NONSEQ, INCR16, 1'b1, OKAY);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0011, 4'b0000, SEQ, INCR16, 1'b1, OKAY);
    end
    checkOutput("midburst_grant", 32'(hgrant_o), 32'h2);
    doReset();
    applyStimulus(4'b0011, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
    checkOutput("after_reset", 32'(hgrant_o), 32'h2);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] req;
      logic [N-1:0] lck;
      logic         rdy;
      logic [1:0]   rsp;
      req = N'($urandom);
      lck = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rdy = ($urandom_range(0, 3) != 0);
      rsp = (!rdy && $urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 2)) : OKAY;
      if (i == 200) doReset();
      applyStimulus(req, lck, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), rdy, rsp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
